dff_sync_sr_monitor: RTL

- Synthesizable response checker for a D flip-flop with synchronous set/reset. It is the observing end of the stimulus interface that drives d/set/reset into such a flop.
- Taps the flop's inputs and its q/qbar outputs, keeps a one-cycle reference model, and compares every checked cycle.
- Counts checks and mismatches, and raises pulse and sticky error flags.
- Sits beside the flop under test in the sequential_ckts benches and in on-chip self-test wrappers.

---
 rtl/dff_sync_sr_monitor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dff_sync_sr_monitor.sv
// Response checker for a D flip-flop with synchronous set/reset.
// Optional complement check on mon_qbar: define DFF_MON_COMPL_CHECK_EN.
module dff_sync_sr_monitor #(
  parameter int CNT_W    = 8,
  parameter bit SET_WINS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mon_d,
  input  logic             mon_set,
  input  logic             mon_rst,
  input  logic             mon_q,
  input  logic             mon_qbar,
  output logic             exp_q,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             active
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t           state_r;
  state_t           state_nx_s;
  logic             exp_q_r;
  logic             err_pulse_r;
  logic             err_sticky_r;
  logic             active_r;
  logic [CNT_W-1:0] check_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             compare_s;
  logic             mismatch_s;

  // Value a correct flop presents after this edge.
  function automatic logic ref_next(input logic d, input logic set, input logic rst);
    logic r;
    if (set && rst) begin
      r = SET_WINS;
    end else if (set) begin
      r = 1'b1;
    end else if (rst) begin
      r = 1'b0;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Next-state decode; leaving CHECK on en=0 suppresses that edge's compare.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE:    state_nx_s = en ? WARMUP : IDLE;
      WARMUP:  state_nx_s = en ? CHECK  : IDLE;
      CHECK:   state_nx_s = en ? CHECK  : IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Compare qualification and verdict for the current edge.
  always_comb begin
    compare_s  = (state_r == CHECK) && en;
`ifdef DFF_MON_COMPL_CHECK_EN
    mismatch_s = (mon_q != exp_q_r) || (mon_qbar != ~mon_q);
`else
    mismatch_s = (mon_q != exp_q_r);
`endif
  end

`ifndef DFF_MON_COMPL_CHECK_EN
  logic unused_qbar_s;
  assign unused_qbar_s = mon_qbar;
`endif

  // State, reference model, counters and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      exp_q_r      <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
      active_r     <= 1'b0;
      check_cnt_r  <= '0;
      err_cnt_r    <= '0;
    end else begin
      state_r     <= state_nx_s;
      active_r    <= (state_nx_s == CHECK);
      exp_q_r     <= ref_next(mon_d, mon_set, mon_rst);
      err_pulse_r <= compare_s && mismatch_s;
      if (compare_s) begin
        check_cnt_r <= sat_inc(check_cnt_r);
        if (mismatch_s) begin
          err_cnt_r    <= sat_inc(err_cnt_r);
          err_sticky_r <= 1'b1;
        end
      end
    end
  end

  assign exp_q      = exp_q_r;
  assign err_pulse  = err_pulse_r;
  assign err_sticky = err_sticky_r;
  assign active     = active_r;
  assign check_cnt  = check_cnt_r;
  assign err_cnt    = err_cnt_r;

endmodule
